// File: rtl/alu_control_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control_mc_if
//  Description : Request/response bundle for the multi-cycle ALU control
//                block. The master drives requests and accepts results; the
//                slave (the ALU) consumes requests and returns results.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_control_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [2:0]       op_code;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, alu_op, funct, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, op_code, zero, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, op_code, zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_control_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control_mc
//  Description : Multi-cycle ALU control and execute unit. Decodes ALUop/funct
//                into a 3-bit operation code, executes single-cycle ops in one
//                cycle and unsigned mult/divu iteratively (one bit per cycle),
//                and returns results over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_control_mc #(
    parameter int WIDTH         = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_control_mc_if.slave  bus
);

    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_SUB  = 3'b110;
    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_SLT  = 3'b111;
    localparam logic [2:0] c_OP_MULT = 3'b011;
    localparam logic [2:0] c_OP_DIVU = 3'b100;

    localparam int            c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);

    // EXEC is the one-cycle decode/execute slot between accept and result,
    // which gives single-cycle ops latency 1 and iterative ops latency WIDTH+1.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              illegal_q, illegal_d;
    logic              zero_q, zero_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [c_CW-1:0]   cnt_q, cnt_d;

    logic [2:0]        w_dec_op;
    logic              w_dec_ill;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_shift;
    logic [WIDTH:0]    w_diff;

    // Decode the incoming request; illegal requests report op_code 000.
    always_comb begin
        w_dec_op  = c_OP_AND;
        w_dec_ill = 1'b0;
        case (bus.alu_op)
            2'b00: w_dec_op = c_OP_ADD;
            2'b01: w_dec_op = c_OP_SUB;
            2'b10: begin
                case (bus.funct)
                    6'b100000: w_dec_op = c_OP_ADD;
                    6'b100010: w_dec_op = c_OP_SUB;
                    6'b100100: w_dec_op = c_OP_AND;
                    6'b100101: w_dec_op = c_OP_OR;
                    6'b101010: w_dec_op = c_OP_SLT;
                    6'b011000: begin
                        if (ENABLE_MULDIV) w_dec_op  = c_OP_MULT;
                        else               w_dec_ill = 1'b1;
                    end
                    6'b011011: begin
                        if (ENABLE_MULDIV) w_dec_op  = c_OP_DIVU;
                        else               w_dec_ill = 1'b1;
                    end
                    default:   w_dec_ill = 1'b1;
                endcase
            end
            default: w_dec_ill = 1'b1;
        endcase
    end

    // One shift-add step ({hi,lo} holds partial product and remaining
    // multiplier bits) and one restoring-division step ({hi,lo} holds
    // partial remainder and quotient/dividend bits).
    always_comb begin
        w_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});
        w_shift = {hi_q, lo_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, b_q};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        zero_d    = zero_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    op_d      = w_dec_ill ? c_OP_AND : w_dec_op;
                    illegal_d = w_dec_ill;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_DONE;
                hi_d    = '0;
                cnt_d   = '0;
                if (illegal_q) begin
                    lo_d = '0;
                end else begin
                    case (op_q)
                        c_OP_ADD: lo_d = a_q + b_q;
                        c_OP_SUB: lo_d = a_q - b_q;
                        c_OP_AND: lo_d = a_q & b_q;
                        c_OP_OR:  lo_d = a_q | b_q;
                        c_OP_SLT: lo_d = ($signed(a_q) < $signed(b_q)) ?
                                         {{(WIDTH - 1){1'b0}}, 1'b1} : '0;
                        c_OP_MULT: begin
                            lo_d    = b_q;
                            state_d = S_MUL;
                        end
                        c_OP_DIVU: begin
                            if (b_q == '0) begin
                                lo_d = '1;
                                hi_d = a_q;
                            end else begin
                                lo_d    = a_q;
                                state_d = S_DIV;
                            end
                        end
                        default: lo_d = '0;
                    endcase
                end
            end
            S_MUL: begin
                hi_d  = w_sum[WIDTH:1];
                lo_d  = {w_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_CNT_LAST) state_d = S_DONE;
            end
            S_DIV: begin
                if (!w_diff[WIDTH]) begin
                    hi_d = w_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = w_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_CNT_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Zero flag is latched once, as the result is published.
        if ((state_d == S_DONE) && (state_q != S_DONE))
            zero_d = (lo_d == '0) && !illegal_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 3'b000;
            illegal_q <= 1'b0;
            zero_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            zero_q    <= zero_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = lo_q;
    assign bus.result_hi = hi_q;
    assign bus.op_code   = op_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_control_mc
//  Description : Directed self-checking bench for alu_control_mc (WIDTH=32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_control_mc;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_control_mc_if #(.WIDTH(WIDTH)) bus ();

    alu_control_mc #(
        .WIDTH         (WIDTH),
        .ENABLE_MULDIV (1'b1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for out_valid; result left pending.
    task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] ia, input logic [31:0] ib,
                          output int lat);
        @(negedge clk);
        check_eq("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
        bus.alu_op   = op;
        bus.funct    = fn;
        bus.a        = ia;
        bus.b        = ib;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    int lat;
    int seen;

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_op    = 2'b00;
        bus.funct     = 6'd0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check_eq("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("rst_result",    {32'd0, bus.result},    64'd0);
        check_eq("rst_result_hi", {32'd0, bus.result_hi}, 64'd0);
        check_eq("rst_op_code",   {61'd0, bus.op_code},   64'd0);
        check_eq("rst_zero",      {63'd0, bus.zero},      64'd0);
        check_eq("rst_illegal",   {63'd0, bus.illegal},   64'd0);
        @(negedge clk);
        rst = 1'b0;

        // sub 5-7
        run_op(2'b10, 6'b100010, 32'd5, 32'd7, lat);
        check_eq("sub_lat",    lat, 64'd1);
        check_eq("sub_op",     {61'd0, bus.op_code}, 64'b110);
        check_eq("sub_result", {32'd0, bus.result},  64'hFFFF_FFFE);
        check_eq("sub_zero",   {63'd0, bus.zero},    64'd0);
        // hold result with out_ready low for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid",    {63'd0, bus.out_valid}, 64'd1);
            check_eq("hold_in_ready", {63'd0, bus.in_ready},  64'd0);
            check_eq("hold_result",   {32'd0, bus.result},    64'hFFFF_FFFE);
            check_eq("hold_op",       {61'd0, bus.op_code},   64'b110);
        end
        consume();
        check_eq("consumed_valid", {63'd0, bus.out_valid}, 64'd0);

        // slt signed: -1 < 1
        run_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, lat);
        check_eq("slt_result", {32'd0, bus.result},  64'd1);
        check_eq("slt_op",     {61'd0, bus.op_code}, 64'b111);
        consume();
        // slt signed: 1 < -1 is false
        run_op(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, lat);
        check_eq("slt2_result", {32'd0, bus.result}, 64'd0);
        check_eq("slt2_zero",   {63'd0, bus.zero},   64'd1);
        consume();

        // lw/sw add wraps
        run_op(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1, lat);
        check_eq("add_result", {32'd0, bus.result},  64'd0);
        check_eq("add_zero",   {63'd0, bus.zero},    64'd1);
        check_eq("add_op",     {61'd0, bus.op_code}, 64'b010);
        consume();

        // beq subtract
        run_op(2'b01, 6'b111111, 32'd9, 32'd9, lat);
        check_eq("beq_result", {32'd0, bus.result},  64'd0);
        check_eq("beq_zero",   {63'd0, bus.zero},    64'd1);
        check_eq("beq_op",     {61'd0, bus.op_code}, 64'b110);
        consume();

        // and / or
        run_op(2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, lat);
        check_eq("and_result", {32'd0, bus.result},  64'h0000_F000);
        check_eq("and_op",     {61'd0, bus.op_code}, 64'b000);
        consume();
        run_op(2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00, lat);
        check_eq("or_result", {32'd0, bus.result},  64'h0000_FFF0);
        check_eq("or_op",     {61'd0, bus.op_code}, 64'b001);
        consume();

        // mult 2^16 * 2^16 = 2^32
        run_op(2'b10, 6'b011000, 32'h0001_0000, 32'h0001_0000, lat);
        check_eq("mul_lat",  lat, 64'd33);
        check_eq("mul_prod", {bus.result_hi, bus.result}, 64'h0000_0001_0000_0000);
        check_eq("mul_zero", {63'd0, bus.zero},    64'd1);
        check_eq("mul_op",   {61'd0, bus.op_code}, 64'b011);
        consume();
        // mult max * max
        run_op(2'b10, 6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check_eq("mulmax_prod", {bus.result_hi, bus.result}, 64'hFFFF_FFFE_0000_0001);
        check_eq("mulmax_zero", {63'd0, bus.zero}, 64'd0);
        consume();

        // divu 100/7
        run_op(2'b10, 6'b011011, 32'd100, 32'd7, lat);
        check_eq("div_lat", lat, 64'd33);
        check_eq("div_q",   {32'd0, bus.result},    64'd14);
        check_eq("div_r",   {32'd0, bus.result_hi}, 64'd2);
        check_eq("div_op",  {61'd0, bus.op_code},   64'b100);
        consume();
        // divu 0xFFFFFFFF/16
        run_op(2'b10, 6'b011011, 32'hFFFF_FFFF, 32'd16, lat);
        check_eq("div2_q", {32'd0, bus.result},    64'h0FFF_FFFF);
        check_eq("div2_r", {32'd0, bus.result_hi}, 64'hF);
        consume();
        // divu by zero
        run_op(2'b10, 6'b011011, 32'd100, 32'd0, lat);
        check_eq("div0_lat",     lat, 64'd1);
        check_eq("div0_q",       {32'd0, bus.result},    64'hFFFF_FFFF);
        check_eq("div0_r",       {32'd0, bus.result_hi}, 64'd100);
        check_eq("div0_illegal", {63'd0, bus.illegal},   64'd0);
        consume();

        // reserved alu_op
        run_op(2'b11, 6'b100000, 32'd3, 32'd4, lat);
        check_eq("ill_lat",     lat, 64'd1);
        check_eq("ill_flag",    {63'd0, bus.illegal},   64'd1);
        check_eq("ill_result",  {32'd0, bus.result},    64'd0);
        check_eq("ill_hi",      {32'd0, bus.result_hi}, 64'd0);
        check_eq("ill_zero",    {63'd0, bus.zero},      64'd0);
        check_eq("ill_op",      {61'd0, bus.op_code},   64'd0);
        consume();
        // undefined funct
        run_op(2'b10, 6'b000000, 32'd3, 32'd4, lat);
        check_eq("illf_flag", {63'd0, bus.illegal}, 64'd1);
        check_eq("illf_op",   {61'd0, bus.op_code}, 64'd0);
        consume();

        // reset in the middle of a mult
        @(negedge clk);
        bus.alu_op   = 2'b10;
        bus.funct    = 6'b011000;
        bus.a        = 32'd3;
        bus.b        = 32'd5;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_valid",    {63'd0, bus.out_valid}, 64'd0);
        check_eq("abort_in_ready", {63'd0, bus.in_ready},  64'd1);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check_eq("abort_no_result", seen, 64'd0);

        // recovery after abort
        run_op(2'b10, 6'b100000, 32'd2, 32'd3, lat);
        check_eq("recover_result", {32'd0, bus.result}, 64'd5);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
